// File: rtl/cve2_sim_timer.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp) for the simulation top.
// Single-cycle response device port; level interrupt when mtime >= mtimecmp.
module cve2_sim_timer #(
  parameter int unsigned PrescaleWidth = 16,
  parameter logic        ResetEnable   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [31:0] dev_addr_i,
  input  logic [3:0]  dev_be_i,
  input  logic [31:0] dev_wdata_i,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic        timer_irq_o
);

  logic [63:0]              mtime_q, mtime_d;
  logic [63:0]              mtimecmp_q, mtimecmp_d;
  logic                     en_q, en_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [PrescaleWidth-1:0] cnt_q, cnt_d;
  logic                     rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     irq_q, irq_d;

  logic [7:0]  reg_idx;
  logic        mapped;
  logic        wr_en;
  logic        tick;
  logic [31:0] be_mask;
  logic [31:0] ctrl_val;
  logic [31:0] ctrl_new;
  logic [31:0] reg_rd;
  logic        unused_bits;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign reg_idx  = dev_addr_i[9:2];
  assign mapped   = (reg_idx <= 8'd4);
  assign wr_en    = dev_req_i & dev_we_i & mapped;
  assign tick     = en_q & (cnt_q == prescale_q);
  assign be_mask  = {{8{dev_be_i[3]}}, {8{dev_be_i[2]}}, {8{dev_be_i[1]}}, {8{dev_be_i[0]}}};
  assign ctrl_new = be_merge(ctrl_val, dev_wdata_i, be_mask);
  // Base and byte-lane address bits are decoded by the bus.
  assign unused_bits = ^{dev_addr_i[31:10], dev_addr_i[1:0], ctrl_new};

  // CTRL register image and read-data mux (pre-update values).
  always_comb begin
    ctrl_val                      = '0;
    ctrl_val[0]                   = en_q;
    ctrl_val[16 +: PrescaleWidth] = prescale_q;
    reg_rd                        = '0;
    unique case (reg_idx)
      8'd0:    reg_rd = mtime_q[31:0];
      8'd1:    reg_rd = mtime_q[63:32];
      8'd2:    reg_rd = mtimecmp_q[31:0];
      8'd3:    reg_rd = mtimecmp_q[63:32];
      8'd4:    reg_rd = ctrl_val;
      default: reg_rd = '0;
    endcase
  end

  // Next-state: prescaler tick, mtime increment, then bus writes override the written bytes.
  always_comb begin
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    if (en_q) begin
      cnt_d = tick ? '0 : cnt_q + PrescaleWidth'(1);
    end
    if (wr_en) begin
      unique case (reg_idx)
        8'd0:    mtime_d[31:0]     = be_merge(mtime_d[31:0], dev_wdata_i, be_mask);
        8'd1:    mtime_d[63:32]    = be_merge(mtime_d[63:32], dev_wdata_i, be_mask);
        8'd2:    mtimecmp_d[31:0]  = be_merge(mtimecmp_q[31:0], dev_wdata_i, be_mask);
        8'd3:    mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], dev_wdata_i, be_mask);
        8'd4: begin
          if (|dev_be_i) begin
            en_d       = ctrl_new[0];
            prescale_d = ctrl_new[16 +: PrescaleWidth];
            cnt_d      = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus response and registered compare.
  always_comb begin
    rvalid_d = dev_req_i;
    err_d    = dev_req_i & ~mapped;
    rdata_d  = '0;
    if (dev_req_i && !dev_we_i && mapped) begin
      rdata_d = reg_rd;
    end
    irq_d = (mtime_q >= mtimecmp_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= ResetEnable;
      prescale_q <= '0;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rdata_q;
  assign dev_err_o    = err_q;
  assign timer_irq_o  = irq_q;

endmodule

// File: tb/tb_cve2_sim_timer.sv
// Self-checking bench for cve2_sim_timer: behavioural model compared every
// cycle, directed scenarios with hand-computed values, then random traffic.
module tb_cve2_sim_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rvalid, err, irq;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cve2_sim_timer #(
    .PrescaleWidth(16),
    .ResetEnable  (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dev_req_i   (req),
    .dev_we_i    (we),
    .dev_addr_i  (addr),
    .dev_be_i    (be),
    .dev_wdata_i (wdata),
    .dev_rvalid_o(rvalid),
    .dev_rdata_o (rdata),
    .dev_err_o   (err),
    .timer_irq_o (irq)
  );

  // ---------------- behavioural model ----------------
  logic [63:0] m_time, m_cmp;
  logic        m_en;
  logic [15:0] m_pre;
  logic [15:0] m_left;   // cycles remaining until the next tick
  logic        e_rvalid, e_err, e_irq;
  logic [31:0] e_rdata;
  logic [7:0]  m_off;
  logic        m_tick;
  logic [63:0] m_nt;
  logic [31:0] m_c;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_word(input logic [7:0] off);
    case (off)
      8'd0:    return m_time[31:0];
      8'd1:    return m_time[63:32];
      8'd2:    return m_cmp[31:0];
      8'd3:    return m_cmp[63:32];
      8'd4:    return {m_pre, 15'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_time = 64'd0; m_cmp = '1; m_en = 1'b1; m_pre = 16'd0; m_left = 16'd0;
      e_rvalid = 1'b0; e_rdata = 32'd0; e_err = 1'b0; e_irq = 1'b0;
    end else begin
      m_off    = addr[9:2];
      e_irq    = (m_time >= m_cmp);
      e_rvalid = req;
      e_err    = req && (m_off > 8'd4);
      e_rdata  = (req && !we && m_off <= 8'd4) ? m_word(m_off) : 32'd0;
      m_tick   = m_en && (m_left == 16'd0);
      m_nt     = m_time + (m_tick ? 64'd1 : 64'd0);
      if (m_en) m_left = m_tick ? m_pre : m_left - 16'd1;
      if (req && we && m_off <= 8'd4) begin
        case (m_off)
          8'd0: m_nt[31:0]  = bmerge(m_nt[31:0], wdata, be);
          8'd1: m_nt[63:32] = bmerge(m_nt[63:32], wdata, be);
          8'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], wdata, be);
          8'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], wdata, be);
          default: begin
            if (be != 4'd0) begin
              m_c    = bmerge(m_word(8'd4), wdata, be);
              m_en   = m_c[0];
              m_pre  = m_c[31:16];
              m_left = m_pre;
            end
          end
        endcase
      end
      m_time = m_nt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rvalid", 32'(rvalid), 32'(e_rvalid));
      check("rdata",  rdata,       e_rdata);
      check("err",    32'(err),    32'(e_err));
      check("irq",    32'(irq),    32'(e_irq));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] rd_v, output logic er);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    check("rsp_latency", 32'(rvalid), 32'd1);
    rd_v = rdata;
    er   = err;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    logic        e;
    bus(1'b1, a, 4'hF, d, v, e);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    logic e;
    bus(1'b0, a, 4'hF, 32'd0, v, e);
  endtask

  initial begin
    logic [31:0] v, a;
    logic        e;
    logic [7:0]  off;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;

    rd(32'h08, v); check("cmpl_reset", v, 32'hFFFF_FFFF);
    rd(32'h0C, v); check("cmph_reset", v, 32'hFFFF_FFFF);

    // PRESCALE=0: one increment per cycle.
    wr(32'h10, 32'h1); wr(32'h04, 32'd0); wr(32'h00, 32'd0);
    repeat (10) @(negedge clk);
    rd(32'h00, v); check("count_p0", v, 32'd11);

    // PRESCALE=3: one increment per four cycles.
    wr(32'h10, 32'd0); wr(32'h00, 32'd0); wr(32'h04, 32'd0);
    wr(32'h10, 32'h0003_0001);
    repeat (10) @(negedge clk);
    rd(32'h00, v); check("count_p3", v, 32'd2);

    // Carry from low into high half.
    wr(32'h10, 32'd0); wr(32'h00, 32'hFFFF_FFFF); wr(32'h04, 32'd0);
    wr(32'h10, 32'h1);
    rd(32'h00, v); check("carry_lo", v, 32'd0);
    rd(32'h04, v); check("carry_hi", v, 32'd1);

    // 64-bit wrap to zero.
    wr(32'h10, 32'd0); wr(32'h00, 32'hFFFF_FFFF); wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h10, 32'h1);
    rd(32'h00, v); check("wrap_lo", v, 32'd0);
    rd(32'h04, v); check("wrap_hi", v, 32'd0);

    // Interrupt rises one cycle after mtime reaches 20.
    wr(32'h10, 32'd0); wr(32'h0C, 32'd0); wr(32'h08, 32'd20);
    wr(32'h00, 32'd0); wr(32'h04, 32'd0);
    wr(32'h10, 32'h1);
    repeat (20) @(negedge clk);
    check("irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
    wr(32'h08, 32'hFFFF_FFFF); wr(32'h0C, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    check("irq_drop", 32'(irq), 32'd0);

    // Byte write coincident with tick from 0x100 gives 0x1AB; one cycle later 0x1AC.
    wr(32'h10, 32'd0); wr(32'h00, 32'hFF); wr(32'h04, 32'd0);
    wr(32'h10, 32'h1);
    bus(1'b1, 32'h00, 4'b0001, 32'h0000_00AB, v, e);
    rd(32'h00, v); check("be_tick", v, 32'h1AC);

    // Freeze: the disabling write still sees a tick, then mtime holds.
    wr(32'h10, 32'd0);
    rd(32'h00, v); check("freeze_a", v, 32'h1AF);
    repeat (50) @(negedge clk);
    rd(32'h00, v); check("freeze_b", v, 32'h1AF);

    // Unmapped offsets.
    bus(1'b0, 32'h20, 4'hF, 32'd0, v, e);
    check("unmapped_rd_err", 32'(e), 32'd1); check("unmapped_rd_data", v, 32'd0);
    bus(1'b1, 32'h3FC, 4'hF, 32'h1234_5678, v, e);
    check("unmapped_wr_err", 32'(e), 32'd1); check("unmapped_wr_data", v, 32'd0);

    // Reset coincident with a read drops the response.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h08; rst_n = 1'b0;
    @(negedge clk);
    req = 1'b0;
    check("reset_drop_rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    rd(32'h00, v); check("post_reset_mtime", v, 32'd1);
    rd(32'h10, v); check("post_reset_ctrl", v, 32'h1);
    rd(32'h08, v); check("post_reset_cmpl", v, 32'hFFFF_FFFF);
    rd(32'h0C, v); check("post_reset_cmph", v, 32'hFFFF_FFFF);

    // Random back-to-back traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      off = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) off = 8'($urandom());
      a = $urandom();
      a[9:2] = off;
      req   = ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 1) != 0);
      addr  = a;
      be    = 4'($urandom());
      wdata = $urandom();
      if (off == 8'd4) begin
        wdata[31:16] = 16'($urandom_range(0, 5));
        wdata[0]     = ($urandom_range(0, 7) != 0);
      end
      if ((off == 8'd1 || off == 8'd3) && $urandom_range(0, 3) != 0)
        wdata = $urandom_range(0, 1);
      if ((off == 8'd0 || off == 8'd2) && $urandom_range(0, 1) != 0)
        wdata = $urandom_range(0, 200);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    req = 1'b0; we = 1'b0; rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cve2_sim_timer.md
Name: cve2_sim_timer

Overview:
Memory-mapped RISC-V machine timer (mtime/mtimecmp) for the simulation top. It sits on a device port of the shared bus, in a 1 kB window at base 0x30000, and drives irq_timer_i of the core. It lets compliance and directed tests exercise timer interrupts without an external testbench agent.

Parameters:
PrescaleWidth, 16, width of the CTRL prescale field and of the internal prescale counter.
ResetEnable, 1'b1, reset value of CTRL.EN.

Ports:
clk_i  input  1  clock; all state updates on its rising edge
rst_ni  input  1  reset; synchronous, active-low
dev_req_i  input  1  bus request; this device is always granted
dev_we_i  input  1  1 = write, 0 = read
dev_addr_i  input  32  byte address; only [9:2] decoded, base decoded by the bus
dev_be_i  input  4  byte enables for writes
dev_wdata_i  input  32  write data
dev_rvalid_o  output  1  response valid, one cycle after dev_req_i
dev_rdata_o  output  32  read data, valid with dev_rvalid_o
dev_err_o  output  1  error response, valid with dev_rvalid_o
timer_irq_o  output  1  level timer interrupt to core

Behaviour:
- Register map (offset = dev_addr_i[9:2]*4):
  - 0x00 MTIMEL
  - 0x04 MTIMEH
  - 0x08 MTIMECMPL
  - 0x0C MTIMECMPH
  - 0x10 CTRL: bit0 EN, bits[16+PrescaleWidth-1:16] PRESCALE, other bits read 0.
  - Offsets 0x14-0x3FC are unmapped.
- Reset values (rst_ni low at a clock edge):
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - EN = ResetEnable; PRESCALE = 0; prescale counter = 0.
  - dev_rvalid_o = 0, dev_rdata_o = 0, dev_err_o = 0, timer_irq_o = 0.
  - Reset mid-transaction drops any pending response. No rvalid is issued for a request accepted in the reset cycle.
- Bus response:
  - Every cycle with dev_req_i=1 produces dev_rvalid_o=1 in the next cycle. No back-pressure; back-to-back requests yield back-to-back responses.
  - Read: dev_rdata_o is the register value sampled in the request cycle, before that cycle's tick/write update.
  - Write: dev_rdata_o = 0.
  - Unmapped offset (read or write): dev_err_o=1 with rvalid, rdata=0, no state change.
  - dev_rdata_o and dev_err_o are 0 whenever dev_rvalid_o=0.
- Writes:
  - Per-byte merge under dev_be_i. be=0 is a legal no-op write that still gets a response.
  - A write to MTIMEL/MTIMEH changes only that 32-bit half; there is no carry into the other half.
  - A write to CTRL clears the prescale counter.
- Tick generation:
  - With EN=1: if counter == PRESCALE, then tick=1 and counter←0; else counter←counter+1.
  - With EN=0: counter holds and no tick.
  - Tick period = PRESCALE+1 cycles.
- mtime update:
  - On tick, mtime ← mtime+1 (64-bit). Wrap from all-ones to 0; carry propagates low→high.
  - A bus write to an MTIME half in the same cycle as a tick wins for the written bytes. Unwritten bytes take the incremented value.
- Interrupt:
  - timer_irq_o ← (mtime >= mtimecmp), a 64-bit unsigned compare on the current register values, registered.
  - The irq therefore asserts one cycle after the compare becomes true and deasserts one cycle after a mtimecmp/mtime write makes it false.
  - Level only; no sticky state.
- Two-half writes to mtimecmp can create transient irq; software writes MTIMECMPH=all-ones first. This is documented behaviour, not guarded.

Test Plan:
- Reset, then read 0x08 and 0x0C → rdata 0xFFFFFFFF each, rvalid exactly 1 cycle after req, err=0, irq=0.
- EN=1, PRESCALE=0, mtime written 0. Read MTIMEL after 10 idle cycles → value 10 ± fixed pipeline offset. Repeat with PRESCALE=3 → increments every 4 cycles.
- Set MTIMEL=0xFFFFFFFF, MTIMEH=0 with PRESCALE=0 → next tick gives MTIMEL=0, MTIMEH=1. Also set both halves all-ones → wraps to 0.
- MTIMECMPH=0, MTIMECMPL=20, mtime=0 → irq rises one cycle after mtime reaches 20. Writing MTIMECMPL=0xFFFFFFFF, MTIMECMPH=0xFFFFFFFF drops irq one cycle later.
- Write MTIMEL with be=4'b0001, wdata=0xAB, coincident with a tick from mtime=0x100 → result 0x1AB.
- Read offset 0x20 → rvalid=1, err=1, rdata=0. CTRL write EN=0 → mtime frozen over 50 cycles. Assert rst_ni during an outstanding read → no rvalid, all registers at reset values.
